// File: rtl/krnl_cam_rtl_result_packer.sv
// Result packer for the CAM write-back path.
// Collects 32-bit search results into 512-bit AXI4-Stream words. Each SEARCH
// session ends with a tlast word: a partial flush, or an empty terminator when
// the last word was already full. Each update-all acknowledge becomes its own
// tlast word. Upstream cannot be stalled, so finished words wait in a small
// first-word-fall-through FIFO. Any word that finds no room is dropped and
// raises a sticky overflow flag.
//
// state code | meaning
// -----------+-------------------------------------------
// 0          | IDLE: no session, results ignored
// 1          | UPDATE_ALL: only acknowledges produce output
// 2          | SEARCH: results are packed into lanes
// 3          | UPDATE_ONE: results ignored
module krnl_cam_rtl_result_packer #(
   parameter int C_DATA_WIDTH  = 512,
   parameter int LANE_WIDTH    = 32,
   parameter int LANES         = C_DATA_WIDTH / LANE_WIDTH,
   parameter int FIFO_DEPTH    = 16,
   parameter int OP_CODE_WIDTH = 3
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic [OP_CODE_WIDTH-1:0]    state,
   input  logic                        s_tvalid,
   input  logic [C_DATA_WIDTH-1:0]     s_tdata,
   input  logic                        s_update_end,
   output logic                        m_tvalid,
   input  logic                        m_tready,
   output logic [C_DATA_WIDTH-1:0]     m_tdata,
   output logic [C_DATA_WIDTH/8-1:0]   m_tkeep,
   output logic                        m_tlast,
   output logic                        overflow,
   output logic [31:0]                 result_count
);

   localparam int KEEP_W     = C_DATA_WIDTH / 8;
   localparam int LANE_BYTES = LANE_WIDTH / 8;
   localparam int PTR_W      = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = FIFO_AW + 1;

   localparam logic [OP_CODE_WIDTH-1:0] ST_IDLE   = OP_CODE_WIDTH'(0);
   localparam logic [OP_CODE_WIDTH-1:0] ST_SEARCH = OP_CODE_WIDTH'(2);

   localparam logic [PTR_W-1:0] LANE_LAST = PTR_W'(LANES - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   // Packing state
   logic [OP_CODE_WIDTH-1:0] state_q;
   logic [PTR_W-1:0]         lane_ptr;
   logic [C_DATA_WIDTH-1:0]  acc;
   logic [C_DATA_WIDTH-1:0]  acc_written;
   logic [KEEP_W-1:0]        flush_keep;

   // Event decode
   logic search_accept;
   logic ack;
   logic session_exit;
   logic full_word;

   // Candidate FIFO writes. The packer word (full or exit) always goes ahead
   // of the acknowledge word when both occur in one cycle.
   logic                    wa_valid;
   logic [C_DATA_WIDTH-1:0] wa_data;
   logic [KEEP_W-1:0]       wa_keep;
   logic                    wa_last;
   logic                    wb_valid;

   // FIFO storage and control
   logic [C_DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic [KEEP_W-1:0]       mem_keep [FIFO_DEPTH];
   logic                    mem_last [FIFO_DEPTH];
   logic [FIFO_AW-1:0]      wr_ptr;
   logic [FIFO_AW-1:0]      rd_ptr;
   logic [FIFO_AW-1:0]      wr_ptr_b;
   logic [CNT_W-1:0]        count;
   logic [CNT_W-1:0]        free_slots;
   logic [CNT_W-1:0]        push_n;
   logic                    keep_a;
   logic                    keep_b;
   logic                    pop;
   logic                    drop;

   // Decode which events happen in this cycle.
   always_comb begin
      search_accept = s_tvalid && !s_update_end && (state == ST_SEARCH);
      ack           = s_tvalid && s_update_end;
      session_exit  = (state_q == ST_SEARCH) && (state != ST_SEARCH);
      full_word     = search_accept && (lane_ptr == LANE_LAST);
   end

   // Accumulator with the incoming result merged into its lane. This gives
   // the complete word in the same cycle that the last lane is written.
   always_comb begin
      acc_written = acc;
      if (search_accept) begin
         acc_written[lane_ptr*LANE_WIDTH +: LANE_WIDTH] = s_tdata[LANE_WIDTH-1:0];
      end
   end

   // Byte enables for a flush: one LANE_BYTES group per filled lane, from the
   // LSB. With lane_ptr == 0 this is all-zero, which yields the terminator.
   always_comb begin
      flush_keep = '0;
      for (int i = 0; i < LANES; i++) begin
         if (i < int'(lane_ptr)) begin
            flush_keep[i*LANE_BYTES +: LANE_BYTES] = '1;
         end
      end
   end

   // Assemble the candidate words for this cycle.
   always_comb begin
      wa_valid = full_word || session_exit;
      wa_data  = full_word ? acc_written : acc;
      wa_keep  = full_word ? {KEEP_W{1'b1}} : flush_keep;
      wa_last  = session_exit;
      wb_valid = ack;
   end

   // Admission control. Space is judged on the occupancy at the start of the
   // cycle, so a pop in the same cycle does not make room. With one free slot
   // the first word is kept and the second dropped.
   always_comb begin
      free_slots = DEPTH_CNT - count;
      keep_a     = wa_valid && (free_slots != '0);
      keep_b     = wb_valid && (free_slots > (keep_a ? CNT_W'(1) : CNT_W'(0)));
      drop       = (wa_valid && !keep_a) || (wb_valid && !keep_b);
      push_n     = CNT_W'(keep_a) + CNT_W'(keep_b);
      pop        = (count != '0) && m_tready;
      wr_ptr_b   = keep_a ? (wr_ptr + FIFO_AW'(1)) : wr_ptr;
   end

   // Register the state code to detect the end of a search session.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state;
      end
   end

   // Lane pointer and accumulator. A full word or a session exit returns
   // both to empty. Reset discards a partial word without flushing it.
   always_ff @(posedge aclk) begin
      if (areset) begin
         lane_ptr <= '0;
         acc      <= '0;
      end else if (session_exit || full_word) begin
         lane_ptr <= '0;
         acc      <= '0;
      end else if (search_accept) begin
         lane_ptr <= lane_ptr + PTR_W'(1);
         acc      <= acc_written;
      end
   end

   // Count accepted search results. The count wraps silently, and results
   // that land in a dropped word still count.
   always_ff @(posedge aclk) begin
      if (areset) begin
         result_count <= '0;
      end else if (search_accept) begin
         result_count <= result_count + 32'd1;
      end
   end

   // Sticky loss flag, cleared only by reset.
   always_ff @(posedge aclk) begin
      if (areset) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end
   end

   // FIFO storage, with up to two writes per cycle into consecutive slots.
   always_ff @(posedge aclk) begin
      if (keep_a) begin
         mem_data[wr_ptr] <= wa_data;
         mem_keep[wr_ptr] <= wa_keep;
         mem_last[wr_ptr] <= wa_last;
      end
      if (keep_b) begin
         mem_data[wr_ptr_b] <= s_tdata;
         mem_keep[wr_ptr_b] <= {KEEP_W{1'b1}};
         mem_last[wr_ptr_b] <= 1'b1;
      end
   end

   // FIFO pointers and occupancy. Pointers wrap modulo FIFO_DEPTH.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + FIFO_AW'(push_n);
         rd_ptr <= rd_ptr + FIFO_AW'(pop);
         count  <= count + push_n - CNT_W'(pop);
      end
   end

   // Fall-through output. The head entry is masked while the FIFO is empty,
   // so the bus reads zero after reset.
   always_comb begin
      m_tvalid = (count != '0);
      m_tdata  = m_tvalid ? mem_data[rd_ptr] : '0;
      m_tkeep  = m_tvalid ? mem_keep[rd_ptr] : '0;
      m_tlast  = m_tvalid ? mem_last[rd_ptr] : 1'b0;
   end

endmodule

// File: tb/tb_krnl_cam_rtl_result_packer.sv
// Testbench for krnl_cam_rtl_result_packer: directed scenarios, then random
// traffic. A queue-based reference model predicts each output word, and a
// negedge monitor checks what the DUT presents.
module tb_krnl_cam_rtl_result_packer;

   typedef struct {
      logic [511:0] data;
      logic [63:0]  keep;
      logic         last;
   } word_t;

   logic         aclk = 1'b0;
   logic         areset;
   logic [2:0]   st;
   logic         tv;
   logic [511:0] td;
   logic         ue;
   logic         rdy;
   logic         m_tvalid;
   logic [511:0] m_tdata;
   logic [63:0]  m_tkeep;
   logic         m_tlast;
   logic         overflow;
   logic [31:0]  result_count;

   int total = 0;
   int bad   = 0;

   krnl_cam_rtl_result_packer dut (
      .aclk         (aclk),
      .areset       (areset),
      .state        (st),
      .s_tvalid     (tv),
      .s_tdata      (td),
      .s_update_end (ue),
      .m_tvalid     (m_tvalid),
      .m_tready     (rdy),
      .m_tdata      (m_tdata),
      .m_tkeep      (m_tkeep),
      .m_tlast      (m_tlast),
      .overflow     (overflow),
      .result_count (result_count)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model. It keeps the pending results of the open session as
   // plain values and the FIFO as a list of whole words.
   logic [31:0] pend [$];
   word_t       sb [$];
   word_t       due [$];
   int          occ = 0;
   int unsigned m_cnt = 0;
   logic        m_ovf = 1'b0;
   logic [2:0]  m_stq = 3'd0;

   function automatic word_t pack(input logic [31:0] q[$], input logic l);
      word_t w;
      w.data = '0;
      w.keep = '0;
      w.last = l;
      for (int i = 0; i < q.size(); i++) begin
         w.data[i*32 +: 32] = q[i];
         w.keep[i*4 +: 4]   = 4'hF;
      end
      return w;
   endfunction

   always @(posedge aclk) begin
      int pop_m;
      int kept;
      word_t w;
      if (areset) begin
         pend.delete();
         sb.delete();
         occ   = 0;
         m_cnt = 0;
         m_ovf = 1'b0;
         m_stq = 3'd0;
      end else begin
         due.delete();
         pop_m = (occ > 0 && rdy) ? 1 : 0;
         if (tv && !ue && st == 3'd2) begin
            pend.push_back(td[31:0]);
            m_cnt++;
            if (pend.size() == 16) begin
               due.push_back(pack(pend, 1'b0));
               pend.delete();
            end
         end
         if (m_stq == 3'd2 && st != 3'd2) begin
            due.push_back(pack(pend, 1'b1));
            pend.delete();
         end
         if (tv && ue) begin
            w.data = td;
            w.keep = '1;
            w.last = 1'b1;
            due.push_back(w);
         end
         kept = 0;
         foreach (due[i]) begin
            if (occ + kept < 16) begin
               sb.push_back(due[i]);
               kept++;
            end else begin
               m_ovf = 1'b1;
            end
         end
         occ   = occ + kept - pop_m;
         m_stq = st;
      end
   end

   // Monitor: compares the head word while it is presented and pops the
   // expectation when the transfer takes place.
   always @(negedge aclk) begin
      chk("m_tvalid", {511'd0, m_tvalid}, {511'd0, occ != 0});
      chk("result_count", {480'd0, result_count}, {480'd0, m_cnt});
      chk("overflow", {511'd0, overflow}, {511'd0, m_ovf});
      if (m_tvalid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word got=%0h want=none t=%0t", m_tdata, $time);
         end else begin
            chk("m_tdata", m_tdata, sb[0].data);
            chk("m_tkeep", {448'd0, m_tkeep}, {448'd0, sb[0].keep});
            chk("m_tlast", {511'd0, m_tlast}, {511'd0, sb[0].last});
            if (rdy) void'(sb.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic idle(input int n);
      tv = 1'b0;
      ue = 1'b0;
      repeat (n) step();
   endtask

   task automatic results(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         tv = 1'b1;
         ue = 1'b0;
         td = 512'(base + i);
         step();
      end
      tv = 1'b0;
   endtask

   initial begin
      areset = 1'b1;
      st  = 3'd0;
      tv  = 1'b0;
      td  = '0;
      ue  = 1'b0;
      rdy = 1'b1;
      step();
      step();
      areset = 1'b0;
      chk("rst_tvalid", {511'd0, m_tvalid}, 512'd0);
      chk("rst_tdata", m_tdata, 512'd0);
      chk("rst_tkeep", {448'd0, m_tkeep}, 512'd0);
      chk("rst_tlast", {511'd0, m_tlast}, 512'd0);
      chk("rst_overflow", {511'd0, overflow}, 512'd0);
      chk("rst_count", {480'd0, result_count}, 512'd0);

      // Full word
      st = 3'd2;
      results(16, 0);
      chk("t1_tvalid", {511'd0, m_tvalid}, 512'd1);
      chk("t1_count", {480'd0, result_count}, 512'd16);
      idle(3);

      // Partial flush
      results(5, 7);
      st = 3'd0;
      idle(4);

      // Terminator after a full word
      st = 3'd2;
      idle(1);
      results(16, 1000);
      st = 3'd0;
      idle(4);

      // Update-all acknowledge
      st = 3'd1;
      tv = 1'b1;
      ue = 1'b1;
      td = 512'd100;
      step();
      idle(3);
      chk("t4_count", {480'd0, result_count}, 512'd37);

      // Overflow with a stalled sink
      rdy = 1'b0;
      st  = 3'd2;
      results(272, 0);
      idle(2);
      chk("t5_overflow", {511'd0, overflow}, 512'd1);
      chk("t5_count", {480'd0, result_count}, 512'd309);
      chk("t5_head_lane0", {480'd0, m_tdata[31:0]}, 512'd0);
      rdy = 1'b1;
      idle(20);
      st = 3'd0;
      idle(3);

      // Reset in the middle of a word
      st = 3'd2;
      results(7, 50);
      areset = 1'b1;
      step();
      areset = 1'b0;
      chk("t6_tvalid", {511'd0, m_tvalid}, 512'd0);
      chk("t6_count", {480'd0, result_count}, 512'd0);
      results(16, 0);
      st = 3'd0;
      idle(4);

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 19) == 0) st = 3'($urandom_range(0, 3));
         tv = $urandom_range(0, 1) == 1;
         ue = $urandom_range(0, 7) == 0;
         for (int k = 0; k < 16; k++) td[k*32 +: 32] = $urandom;
         rdy = $urandom_range(0, 3) != 0;
         areset = $urandom_range(0, 999) == 0;
         step();
      end
      areset = 1'b0;
      st  = 3'd0;
      rdy = 1'b1;
      idle(2);
      for (int c = 0; c < 200 && sb.size() != 0; c++) step();
      idle(2);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d want=0 words_left", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
